wb_rr_arbiter: RTL

//  Round-robin Wishbone classic arbiter that shares one slave (the block RAM) between NM masters.

---
 rtl/wb_arb_pkg.sv | 9 +
 rtl/wb_rr_arbiter_rr_pick.sv | 35 +++
 rtl/wb_rr_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the Wishbone round-robin arbiter: FSM encoding and the
// supported master count ceiling.
package wb_arb_pkg;

   typedef enum logic {IDLE, BUSY} arb_state_t;

   localparam int MAX_NM = 4;

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after `last`,
// found by rotating a doubled request vector and priority-encoding it.
module rr_pick #(
   parameter int NM = 2
) (
   input  logic [NM-1:0]         req,
   input  logic [$clog2(NM)-1:0] last,
   output logic [NM-1:0]         onehot,
   output logic [$clog2(NM)-1:0] idx
);

   localparam int IW = $clog2(NM);

   logic [NM-1:0] rot;
   int            off;
   int            pos;

   always_comb begin
      // rot[i] is the request of master (last + 1 + i) mod NM
      rot = NM'({req, req} >> (32'(last) + 32'd1));
      off = 0;
      for (int i = NM - 1; i >= 0; i--) begin
         if (rot[i]) off = i;
      end
      pos = int'(last) + 1 + off;
      if (pos >= NM) pos = pos - NM;
      onehot = '0;
      idx    = '0;
      if (|rot) begin
         onehot = NM'(1) << pos;
         idx    = IW'(pos);
      end
   end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter sharing one slave between NM masters,
// with a registered grant and a per-access watchdog that ends hung beats with err.
module wb_rr_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NM      = 2,
   parameter int AW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NM-1:0]  m_cyc,
   input  logic [NM-1:0]  m_stb,
   input  logic [NM-1:0]  m_we,
   input  logic [AW-1:0]  m_adr [NM],
   input  logic [3:0]     m_sel [NM],
   input  logic [31:0]    m_dat_ms [NM],
   output logic [NM-1:0]  m_ack,
   output logic [NM-1:0]  m_err,
   output logic [NM-1:0]  m_rty,
   output logic [31:0]    m_dat_sm,
   output logic           s_cyc,
   output logic           s_stb,
   output logic           s_we,
   output logic [AW-1:0]  s_adr,
   output logic [3:0]     s_sel,
   output logic [31:0]    s_dat_ms,
   input  logic           s_ack,
   input  logic           s_err,
   input  logic           s_rty,
   input  logic [31:0]    s_dat_sm,
   output logic [NM-1:0]  gnt
);

   localparam int IW  = $clog2(NM);
   localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

   arb_state_t     state, state_nxt;
   logic [NM-1:0]  gnt_nxt;
   logic [IW-1:0]  last, last_nxt;
   logic [WDW-1:0] wdog, wdog_nxt;

   logic [NM-1:0]  pick_oh;
   logic [IW-1:0]  pick_idx;

   logic busy, cur_cyc, raw_stb, term, wd_hit, wd_err;

   rr_pick #(.NM(NM)) u_pick (
      .req    (m_cyc),
      .last   (last),
      .onehot (pick_oh),
      .idx    (pick_idx)
   );

   // While BUSY, `last` always holds the index of the granted master.
   always_comb begin
      busy    = (state == BUSY);
      cur_cyc = busy & m_cyc[last];
      raw_stb = cur_cyc & m_stb[last];
      term    = s_ack | s_err | s_rty;
      // Strobe is pulled on the timeout cycle regardless of ack so that a
      // zero-wait slave cannot form a loop through the watchdog.
      wd_hit  = (TIMEOUT > 0) && raw_stb && (wdog == WD_LAST);
      wd_err  = wd_hit & ~term;
   end

   always_comb begin
      s_cyc    = cur_cyc;
      s_stb    = raw_stb & ~wd_hit;
      s_we     = busy & m_we[last];
      s_adr    = busy ? m_adr[last]    : '0;
      s_sel    = busy ? m_sel[last]    : '0;
      s_dat_ms = busy ? m_dat_ms[last] : '0;
      m_ack    = {NM{cur_cyc & s_ack}} & gnt;
      m_err    = {NM{cur_cyc & (s_err | wd_err)}} & gnt;
      m_rty    = {NM{cur_cyc & s_rty}} & gnt;
      m_dat_sm = busy ? s_dat_sm : '0;
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      last_nxt  = last;
      unique case (state)
         IDLE: begin
            if (|m_cyc) begin
               gnt_nxt   = pick_oh;
               last_nxt  = pick_idx;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (!m_cyc[last]) begin
               gnt_nxt   = '0;
               state_nxt = IDLE;
            end
         end
         default: begin
            gnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      wdog_nxt = wdog;
      if (!raw_stb || term || wd_hit) wdog_nxt = '0;
      else if (wdog != '1)            wdog_nxt = wdog + WDW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         gnt   <= '0;
         last  <= IW'(NM - 1);
         wdog  <= '0;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         last  <= last_nxt;
         wdog  <= wdog_nxt;
      end
   end

endmodule
